// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int MAX_CTRL_W = 64;

  // Control word of an empty slot; sliced to CTRL_W by users.
  localparam logic [MAX_CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data entry. Control bits are stored and presented as zero
// whenever the entry is not valid, so a bubble cannot carry live enables.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q  <= 1'b0;
      ctrl_q <= BUBBLE_CTRL[CTRL_W-1:0];
      data_q <= '0;
    end else if (load) begin
      vld_q  <= 1'b1;
      ctrl_q <= ld_ctrl;
      data_q <= ld_data;
    end else if (drop) begin
      // Payload is left in place; only the control side becomes a bubble.
      vld_q  <= 1'b0;
      ctrl_q <= BUBBLE_CTRL[CTRL_W-1:0];
    end
  end

  assign vld  = vld_q;
  assign ctrl = vld_q ? ctrl_q : BUBBLE_CTRL[CTRL_W-1:0];
  assign data = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic stage register between adjacent pipeline stages: valid/ready
// handshake, optional two-entry skid buffer, flush that leaves a true bubble.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  state_e state_q, state_d;

  logic              flush, xin, xout;
  logic              m_load, m_sel_s, m_drop, s_load, s_drop;
  logic              m_vld;
  logic [CTRL_W-1:0] m_ctrl, m_ld_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_ld_data, s_data;

  assign flush = RST | CLR;
  assign xin   = in_valid & in_ready;
  assign xout  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_load  = 1'b0;
    m_sel_s = 1'b0;
    m_drop  = 1'b0;
    s_load  = 1'b0;
    s_drop  = 1'b0;
    case (state_q)
      EMPTY: if (xin) begin
        m_load  = 1'b1;
        state_d = HALF;
      end
      HALF: begin
        if (xin && xout) begin
          m_load = 1'b1;
        end else if (xin && SKID) begin
          // Downstream stalled: park the younger entry behind M.
          s_load  = 1'b1;
          state_d = FULL;
        end else if (xout) begin
          m_drop  = 1'b1;
          state_d = EMPTY;
        end
      end
      FULL: if (xout) begin
        m_load  = 1'b1;
        m_sel_s = 1'b1;
        s_drop  = 1'b1;
        state_d = HALF;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  assign m_ld_ctrl = m_sel_s ? s_ctrl : in_ctrl;
  assign m_ld_data = m_sel_s ? s_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .clr     (flush),
    .load    (m_load),
    .drop    (m_drop),
    .ld_ctrl (m_ld_ctrl),
    .ld_data (m_ld_data),
    .vld     (m_vld),
    .ctrl    (m_ctrl),
    .data    (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;
      logic s_vld;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .clr     (flush),
        .load    (s_load),
        .drop    (s_drop),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .vld     (s_vld),
        .ctrl    (s_ctrl),
        .data    (s_data)
      );

      // Registered ready: looks at the next state, never at out_ready directly.
      always_ff @(posedge clk) begin
        if (RST)      in_ready_q <= 1'b0;
        else if (CLR) in_ready_q <= 1'b1;
        else          in_ready_q <= (state_d != FULL);
      end

      logic unused_skid;
      assign unused_skid = s_vld;
      assign in_ready    = in_ready_q;
    end else begin : g_single
      logic unused_single;
      assign unused_single = ^{s_load, s_drop};
      assign s_ctrl   = '0;
      assign s_data   = '0;
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = (out_valid & m_vld) ? m_ctrl : BUBBLE_CTRL[CTRL_W-1:0];
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench: one skid-mode and one single-register instance.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST, CLR;

  logic        iv1, irdy1, ov1, ordy1;
  logic [7:0]  ic1, oc1;
  logic [31:0] id1, od1;
  logic [1:0]  occ1;

  logic        iv0, irdy0, ov0, ordy0;
  logic [7:0]  ic0, oc0;
  logic [31:0] id0, od0;
  logic [1:0]  occ0;

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1'b1)) u_dut (
    .clk(clk), .RST(RST), .CLR(CLR),
    .in_valid(iv1), .in_ready(irdy1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_ctrl(oc1), .out_data(od1),
    .occ(occ1)
  );

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1'b0)) u_dut0 (
    .clk(clk), .RST(RST), .CLR(CLR),
    .in_valid(iv0), .in_ready(irdy0), .in_ctrl(ic0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_ctrl(oc0), .out_data(od0),
    .occ(occ0)
  );

  typedef struct {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];

  int nchecks = 0;
  int nerrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample at negedge with inputs stable, then advance one rising edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    if (RST || CLR) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ov1 && ordy1) begin
        if (q1.size() == 0) check("skid_unexpected_out", od1, 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          check("skid_data", od1, e.d);
          check("skid_ctrl", {24'd0, oc1}, {24'd0, e.c});
        end
      end
      if (iv1 && irdy1) q1.push_back('{c: ic1, d: id1});
      if (ov0 && ordy0) begin
        if (q0.size() == 0) check("single_unexpected_out", od0, 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          check("single_data", od0, e.d);
          check("single_ctrl", {24'd0, oc0}, {24'd0, e.c});
        end
      end
      if (iv0 && irdy0) q0.push_back('{c: ic0, d: id0});
      check("single_ready_comb", {31'd0, irdy0}, {31'd0, ordy0 | ~ov0});
      check("single_occ_le1", {31'd0, occ0 <= 2'd1}, 32'd1);
    end
    if (!ov1) check("skid_bubble_ctrl", {24'd0, oc1}, 32'd0);
    if (!ov0) check("single_bubble_ctrl", {24'd0, oc0}, 32'd0);
    if (ov1) check("skid_no_dead", {31'd0, od1 == 32'hDEAD}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0;
    iv1 = 0; ic1 = '0; id1 = '0; ordy1 = 0;
    iv0 = 0; ic0 = '0; id0 = '0; ordy0 = 0;

    // Reset for two cycles
    tick();
    tick();
    RST = 1'b0;
    check("rst_in_ready0", {31'd0, irdy1}, 32'd0);
    check("rst_out_valid", {31'd0, ov1}, 32'd0);
    check("rst_out_ctrl", {24'd0, oc1}, 32'd0);
    check("rst_out_data", od1, 32'd0);
    check("rst_occ", {30'd0, occ1}, 32'd0);
    check("rst_single_occ", {30'd0, occ0}, 32'd0);
    tick();
    check("rst_in_ready1", {31'd0, irdy1}, 32'd1);

    // Full-rate stream
    ordy1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; id1 = 32'h100 + i; ic1 = 8'h81;
      tick();
      check("stream_latency", od1, 32'h100 + i);
      check("stream_occ", {30'd0, occ1}, 32'd1);
      check("stream_ready", {31'd0, irdy1}, 32'd1);
    end
    iv1 = 1'b0;
    tick();
    check("stream_drain", q1.size(), 32'd0);
    check("stream_empty_occ", {30'd0, occ1}, 32'd0);

    // Stall: A then B go into M and S; C must be refused
    ordy1 = 1'b0;
    iv1 = 1'b1; id1 = 32'h200; ic1 = 8'h11;
    tick();
    check("stall_half_ready", {31'd0, irdy1}, 32'd1);
    id1 = 32'h201; ic1 = 8'h12;
    tick();
    check("stall_full_occ", {30'd0, occ1}, 32'd2);
    check("stall_full_ready", {31'd0, irdy1}, 32'd0);
    check("stall_head", od1, 32'h200);
    id1 = 32'h202; ic1 = 8'h13;
    tick();
    check("stall_hold_occ", {30'd0, occ1}, 32'd2);
    iv1 = 1'b0; ordy1 = 1'b1;
    tick();
    check("stall_second", od1, 32'h201);
    check("stall_half_occ", {30'd0, occ1}, 32'd1);
    tick();
    tick();
    check("stall_drain", q1.size(), 32'd0);
    check("stall_empty_occ", {30'd0, occ1}, 32'd0);

    // Flush while full, with a live input that must be squashed
    ordy1 = 1'b0;
    iv1 = 1'b1; id1 = 32'h300; ic1 = 8'h21;
    tick();
    id1 = 32'h301; ic1 = 8'h22;
    tick();
    check("clr_pre_occ", {30'd0, occ1}, 32'd2);
    id1 = 32'hDEAD; ic1 = 8'h5A; ordy1 = 1'b1; CLR = 1'b1;
    tick();
    CLR = 1'b0; iv1 = 1'b0;
    check("clr_occ", {30'd0, occ1}, 32'd0);
    check("clr_out_valid", {31'd0, ov1}, 32'd0);
    check("clr_out_ctrl", {24'd0, oc1}, 32'd0);
    check("clr_out_data", od1, 32'd0);
    check("clr_in_ready", {31'd0, irdy1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_stays_empty", {31'd0, ov1}, 32'd0);
    end

    // Bubbles with all control bits set on the input
    iv1 = 1'b0; ic1 = 8'hFF; id1 = 32'h5555;
    for (int i = 0; i < 6; i++) begin
      ordy1 = i[0];
      tick();
      check("bubble_ctrl", {24'd0, oc1}, 32'd0);
    end

    // Single-register mode with a toggling consumer
    iv0 = 1'b1; ic0 = 8'h42;
    for (int i = 0; i < 12; i++) begin
      id0 = 32'h400 + i;
      ordy0 = ~i[0];
      tick();
    end
    iv0 = 1'b0; ordy0 = 1'b1;
    tick();
    tick();
    check("single_drain", q0.size(), 32'd0);

    // Mixed random traffic on both instances
    for (int i = 0; i < 200; i++) begin
      iv1 = 1'($urandom_range(0, 1)); ordy1 = 1'($urandom_range(0, 1));
      ic1 = 8'($urandom); id1 = 32'h1000 + i;
      iv0 = 1'($urandom_range(0, 1)); ordy0 = 1'($urandom_range(0, 1));
      ic0 = 8'($urandom); id0 = 32'h2000 + i;
      tick();
    end
    iv1 = 1'b0; iv0 = 1'b0; ordy1 = 1'b1; ordy0 = 1'b1;
    tick();
    tick();
    tick();
    check("rand_drain_skid", q1.size(), 32'd0);
    check("rand_drain_single", q0.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
